// File: rtl/riscv_pipe_pkg.sv
// Shared types for the RV32 pipeline stage registers: writeback select encoding
// and the control/data bundles carried from EX into MEM.
package riscv_pipe_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        wb_sel_t    wb_sel;
        logic [2:0] funct3;
    } ex_mem_ctrl_t;

    typedef struct packed {
        logic [XLEN_DEF-1:0]   alu_result;
        logic [XLEN_DEF-1:0]   rs2_data;
        logic [XLEN_DEF-1:0]   pc_p_4;
        logic [REG_AW_DEF-1:0] rd;
    } ex_mem_data_t;

endpackage

// File: rtl/ex_mem_pipe_stage_chk.sv
// Protocol checks on the EX-side inputs of the EX->MEM stage.
module ex_mem_pipe_stage_chk (
    input logic       clk,
    input logic       reset,
    input logic       valid_ex,
    input logic       mem_read_ex,
    input logic       mem_write_ex,
    input logic [1:0] wb_sel_ex
);

    a_no_read_and_write: assert property (@(negedge clk) disable iff (reset)
        !(valid_ex && mem_read_ex && mem_write_ex))
        else $error("ex_mem: mem_read_ex and mem_write_ex both set");

    a_no_reserved_wb_sel: assert property (@(negedge clk) disable iff (reset)
        !(valid_ex && (wb_sel_ex == 2'd3)))
        else $error("ex_mem: reserved wb_sel_ex value with valid_ex");

endmodule

// File: rtl/pipe_stage_reg.sv
// Falling-edge pipeline register with reset > flush > stall > load priority.
// On flush the contents are either cleared or held, selected by ZERO_ON_FLUSH.
module pipe_stage_reg #(
    parameter int           W             = 1,
    parameter bit           ZERO_ON_FLUSH = 1'b1,
    parameter logic [W-1:0] RESET_VAL     = {W{1'b0}}
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_r;

    // stage register, updated on the falling edge
    always_ff @(negedge clk) begin
        if (reset) begin
            q_r <= RESET_VAL;
        end else if (flush) begin
            if (ZERO_ON_FLUSH) begin
                q_r <= {W{1'b0}};
            end else begin
                q_r <= q_r;
            end
        end else if (stall) begin
            q_r <= q_r;
        end else begin
            q_r <= d;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline register for the RV32 core: valid tracking, stall/flush,
// gated control, MEM-stage forwarding tap and saturating stall/bubble counters.
module ex_mem_pipe_stage
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int REG_AW        = 5,
    parameter int STAT_W        = 16,
    parameter bit ZERO_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_ex,
    input  logic [XLEN-1:0]   alu_result_ex,
    input  logic [XLEN-1:0]   rs2_data_ex,
    input  logic [XLEN-1:0]   pc_p_4_ex,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic              reg_write_ex,
    input  logic              mem_read_ex,
    input  logic              mem_write_ex,
    input  logic [1:0]        wb_sel_ex,
    input  logic [2:0]        funct3_ex,
    output logic              valid_mem,
    output logic [XLEN-1:0]   alu_result_mem,
    output logic [XLEN-1:0]   rs2_data_mem,
    output logic [XLEN-1:0]   pc_p_4_mem,
    output logic [REG_AW-1:0] rd_mem,
    output logic              reg_write_mem,
    output logic              mem_read_mem,
    output logic              mem_write_mem,
    output logic [1:0]        wb_sel_mem,
    output logic [2:0]        funct3_mem,
    output logic              fwd_en_mem,
    output logic [REG_AW-1:0] fwd_rd_mem,
    output logic [XLEN-1:0]   fwd_data_mem,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] bubble_cnt
);

    localparam int CTRL_W = 1 + $bits(ex_mem_ctrl_t);
    localparam int DATA_W = 3 * XLEN + REG_AW;

    ex_mem_ctrl_t      ctrl_d_s;
    ex_mem_ctrl_t      ctrl_q_s;
    logic              valid_q_s;
    logic [CTRL_W-1:0] vc_d_s;
    logic [CTRL_W-1:0] vc_q_s;
    logic [DATA_W-1:0] data_d_s;
    logic [DATA_W-1:0] data_q_s;
    logic              stall_ev_s;
    logic              bubble_ev_s;
    logic [XLEN-1:0]   fwd_data_s;
    logic [STAT_W-1:0] stall_cnt_r;
    logic [STAT_W-1:0] bubble_cnt_r;

    // control gating: invalid slots and x0 writes never reach MEM; a store beats a load
    always_comb begin
        ctrl_d_s           = '0;
        ctrl_d_s.reg_write = reg_write_ex & valid_ex & (rd_ex != {REG_AW{1'b0}});
        ctrl_d_s.mem_write = mem_write_ex & valid_ex;
        ctrl_d_s.mem_read  = mem_read_ex & valid_ex & ~mem_write_ex;
        ctrl_d_s.wb_sel    = wb_sel_t'(wb_sel_ex);
        ctrl_d_s.funct3    = funct3_ex;
    end

    assign vc_d_s   = {valid_ex, ctrl_d_s};
    assign data_d_s = {alu_result_ex, rs2_data_ex, pc_p_4_ex, rd_ex};

    // valid and control always clear on flush so a bubble can never write anything
    pipe_stage_reg #(
        .W             (CTRL_W),
        .ZERO_ON_FLUSH (1'b1),
        .RESET_VAL     ({CTRL_W{1'b0}})
    ) u_ctrl_reg (
        .clk   (clk),
        .reset (reset),
        .stall (stall),
        .flush (flush),
        .d     (vc_d_s),
        .q     (vc_q_s)
    );

    pipe_stage_reg #(
        .W             (DATA_W),
        .ZERO_ON_FLUSH (ZERO_ON_FLUSH),
        .RESET_VAL     ({DATA_W{1'b0}})
    ) u_data_reg (
        .clk   (clk),
        .reset (reset),
        .stall (stall),
        .flush (flush),
        .d     (data_d_s),
        .q     (data_q_s)
    );

    ex_mem_pipe_stage_chk u_chk (
        .clk          (clk),
        .reset        (reset),
        .valid_ex     (valid_ex),
        .mem_read_ex  (mem_read_ex),
        .mem_write_ex (mem_write_ex),
        .wb_sel_ex    (wb_sel_ex)
    );

    assign {valid_q_s, ctrl_q_s} = vc_q_s;
    assign {alu_result_mem, rs2_data_mem, pc_p_4_mem, rd_mem} = data_q_s;

    assign valid_mem     = valid_q_s;
    assign reg_write_mem = ctrl_q_s.reg_write;
    assign mem_read_mem  = ctrl_q_s.mem_read;
    assign mem_write_mem = ctrl_q_s.mem_write;
    assign wb_sel_mem    = ctrl_q_s.wb_sel;
    assign funct3_mem    = ctrl_q_s.funct3;

    // forwarding value: link address for JAL/JALR, otherwise the ALU result
    always_comb begin
        fwd_data_s = alu_result_mem;
        if (ctrl_q_s.wb_sel == WB_PC4) begin
            fwd_data_s = pc_p_4_mem;
        end else begin
            fwd_data_s = alu_result_mem;
        end
    end

    assign fwd_en_mem   = valid_q_s & ctrl_q_s.reg_write & ~ctrl_q_s.mem_read;
    assign fwd_rd_mem   = rd_mem;
    assign fwd_data_mem = fwd_data_s;

    assign stall_ev_s  = stall & ~flush;
    assign bubble_ev_s = flush | (~stall & ~valid_ex);

    // saturating statistics counters
    always_ff @(negedge clk) begin
        if (reset) begin
            stall_cnt_r  <= {STAT_W{1'b0}};
            bubble_cnt_r <= {STAT_W{1'b0}};
        end else begin
            if (stall_ev_s && (stall_cnt_r != {STAT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + {{(STAT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (bubble_ev_s && (bubble_cnt_r != {STAT_W{1'b1}})) begin
                bubble_cnt_r <= bubble_cnt_r + {{(STAT_W-1){1'b0}}, 1'b1};
            end else begin
                bubble_cnt_r <= bubble_cnt_r;
            end
        end
    end

    assign stall_cnt  = stall_cnt_r;
    assign bubble_cnt = bubble_cnt_r;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Scoreboard bench for ex_mem_pipe_stage: default instance plus ZERO_ON_FLUSH=0
// and STAT_W=4 variants driven with the same directed stimulus.
module tb_ex_mem_pipe_stage;

    logic        clk = 1'b1;
    logic        reset, stall, flush, valid_ex;
    logic [31:0] alu_ex, rs2_ex, pc4_ex;
    logic [4:0]  rd_ex;
    logic        rw_ex, mr_ex, mw_ex;
    logic [1:0]  wb_ex;
    logic [2:0]  f3_ex;

    logic        valid_m, rw_m, mr_m, mw_m, fen_m;
    logic [31:0] alu_m, rs2_m, pc4_m, fdata_m;
    logic [4:0]  rd_m, frd_m;
    logic [1:0]  wb_m;
    logic [2:0]  f3_m;
    logic [15:0] scnt_m, bcnt_m;

    logic        z_valid, z_rw, z_mr, z_mw, z_fen;
    logic [31:0] z_alu, z_rs2, z_pc4, z_fdata;
    logic [4:0]  z_rd, z_frd;
    logic [1:0]  z_wb;
    logic [2:0]  z_f3;
    logic [15:0] z_scnt, z_bcnt;

    logic        s_valid, s_rw, s_mr, s_mw, s_fen;
    logic [31:0] s_alu, s_rs2, s_pc4, s_fdata;
    logic [4:0]  s_rd, s_frd;
    logic [1:0]  s_wb;
    logic [2:0]  s_f3;
    logic [3:0]  s_scnt, s_bcnt;

    always #5 clk = ~clk;

    ex_mem_pipe_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_ex(valid_ex),
        .alu_result_ex(alu_ex), .rs2_data_ex(rs2_ex), .pc_p_4_ex(pc4_ex), .rd_ex(rd_ex),
        .reg_write_ex(rw_ex), .mem_read_ex(mr_ex), .mem_write_ex(mw_ex), .wb_sel_ex(wb_ex),
        .funct3_ex(f3_ex), .valid_mem(valid_m), .alu_result_mem(alu_m), .rs2_data_mem(rs2_m),
        .pc_p_4_mem(pc4_m), .rd_mem(rd_m), .reg_write_mem(rw_m), .mem_read_mem(mr_m),
        .mem_write_mem(mw_m), .wb_sel_mem(wb_m), .funct3_mem(f3_m), .fwd_en_mem(fen_m),
        .fwd_rd_mem(frd_m), .fwd_data_mem(fdata_m), .stall_cnt(scnt_m), .bubble_cnt(bcnt_m)
    );

    ex_mem_pipe_stage #(.ZERO_ON_FLUSH(1'b0)) dut_zf0 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_ex(valid_ex),
        .alu_result_ex(alu_ex), .rs2_data_ex(rs2_ex), .pc_p_4_ex(pc4_ex), .rd_ex(rd_ex),
        .reg_write_ex(rw_ex), .mem_read_ex(mr_ex), .mem_write_ex(mw_ex), .wb_sel_ex(wb_ex),
        .funct3_ex(f3_ex), .valid_mem(z_valid), .alu_result_mem(z_alu), .rs2_data_mem(z_rs2),
        .pc_p_4_mem(z_pc4), .rd_mem(z_rd), .reg_write_mem(z_rw), .mem_read_mem(z_mr),
        .mem_write_mem(z_mw), .wb_sel_mem(z_wb), .funct3_mem(z_f3), .fwd_en_mem(z_fen),
        .fwd_rd_mem(z_frd), .fwd_data_mem(z_fdata), .stall_cnt(z_scnt), .bubble_cnt(z_bcnt)
    );

    ex_mem_pipe_stage #(.STAT_W(4)) dut_s4 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_ex(valid_ex),
        .alu_result_ex(alu_ex), .rs2_data_ex(rs2_ex), .pc_p_4_ex(pc4_ex), .rd_ex(rd_ex),
        .reg_write_ex(rw_ex), .mem_read_ex(mr_ex), .mem_write_ex(mw_ex), .wb_sel_ex(wb_ex),
        .funct3_ex(f3_ex), .valid_mem(s_valid), .alu_result_mem(s_alu), .rs2_data_mem(s_rs2),
        .pc_p_4_mem(s_pc4), .rd_mem(s_rd), .reg_write_mem(s_rw), .mem_read_mem(s_mr),
        .mem_write_mem(s_mw), .wb_sel_mem(s_wb), .funct3_mem(s_f3), .fwd_en_mem(s_fen),
        .fwd_rd_mem(s_frd), .fwd_data_mem(s_fdata), .stall_cnt(s_scnt), .bubble_cnt(s_bcnt)
    );

    typedef struct {
        logic        valid, rw, mr, mw;
        logic [1:0]  wb;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] alu, rs2, pc4;
        logic        fen;
        logic [31:0] fdata;
        logic [15:0] scnt, bcnt;
        bit          chk_zf;
        logic        zf_valid;
        logic [31:0] zf_alu;
        bit          chk_s4;
        logic [3:0]  s4_scnt;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t mk(input logic v, rw, mr, mw, input logic [1:0] wb,
                                input logic [2:0] f3, input logic [4:0] rd,
                                input logic [31:0] alu, rs2, pc4, input logic fen,
                                input logic [31:0] fdata, input logic [15:0] scnt, bcnt);
        exp_t e;
        e.valid = v;  e.rw = rw;  e.mr = mr;  e.mw = mw;
        e.wb = wb;  e.f3 = f3;  e.rd = rd;
        e.alu = alu;  e.rs2 = rs2;  e.pc4 = pc4;
        e.fen = fen;  e.fdata = fdata;  e.scnt = scnt;  e.bcnt = bcnt;
        e.chk_zf = 1'b0;  e.zf_valid = 1'b0;  e.zf_alu = 32'h0;
        e.chk_s4 = 1'b0;  e.s4_scnt = 4'h0;
        return e;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exv);
        total++;
        if (act !== exv) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exv, $time);
        end
    endtask

    task automatic drive(input logic r, st, fl, v, input logic [31:0] alu, rs2, pc4,
                         input logic [4:0] rd, input logic rw, mr, mw,
                         input logic [1:0] wb, input logic [2:0] f3);
        reset = r;  stall = st;  flush = fl;  valid_ex = v;
        alu_ex = alu;  rs2_ex = rs2;  pc4_ex = pc4;  rd_ex = rd;
        rw_ex = rw;  mr_ex = mr;  mw_ex = mw;  wb_ex = wb;  f3_ex = f3;
    endtask

    // queue the expectation for the coming falling edge, then advance one cycle
    task automatic step(input exp_t e);
        q.push_back(e);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // monitor: every falling edge produces one stage state to check
    always @(negedge clk) begin
        #2;
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            cmp("valid_mem", 32'(valid_m), 32'(mon_e.valid));
            cmp("reg_write_mem", 32'(rw_m), 32'(mon_e.rw));
            cmp("mem_read_mem", 32'(mr_m), 32'(mon_e.mr));
            cmp("mem_write_mem", 32'(mw_m), 32'(mon_e.mw));
            cmp("wb_sel_mem", 32'(wb_m), 32'(mon_e.wb));
            cmp("funct3_mem", 32'(f3_m), 32'(mon_e.f3));
            cmp("rd_mem", 32'(rd_m), 32'(mon_e.rd));
            cmp("alu_result_mem", alu_m, mon_e.alu);
            cmp("rs2_data_mem", rs2_m, mon_e.rs2);
            cmp("pc_p_4_mem", pc4_m, mon_e.pc4);
            cmp("fwd_en_mem", 32'(fen_m), 32'(mon_e.fen));
            cmp("fwd_rd_mem", 32'(frd_m), 32'(mon_e.rd));
            cmp("fwd_data_mem", fdata_m, mon_e.fdata);
            cmp("stall_cnt", 32'(scnt_m), 32'(mon_e.scnt));
            cmp("bubble_cnt", 32'(bcnt_m), 32'(mon_e.bcnt));
            if (mon_e.chk_zf) begin
                cmp("zf0_valid_mem", 32'(z_valid), 32'(mon_e.zf_valid));
                cmp("zf0_alu_result_mem", z_alu, mon_e.zf_alu);
            end
            if (mon_e.chk_s4) begin
                cmp("s4_stall_cnt", 32'(s_scnt), 32'(mon_e.s4_scnt));
            end
        end
    end

    initial begin
        exp_t e;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
        #1;

        // reset with random inputs, second edge also asserts stall and flush
        drive(1'b1, 1'b0, 1'b0, 1'b1, $urandom, $urandom, $urandom, 5'($urandom), 1'b1,
              1'b0, 1'b1, 2'($urandom_range(0, 2)), 3'($urandom));
        step(mk(0,0,0,0, 2'd0, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 16'd0, 16'd0));
        drive(1'b1, 1'b1, 1'b1, 1'b1, $urandom, $urandom, $urandom, 5'($urandom), 1'b1,
              1'b0, 1'b0, 2'($urandom_range(0, 2)), 3'($urandom));
        step(mk(0,0,0,0, 2'd0, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 16'd0, 16'd0));

        // plain ALU load, forwarded next edge
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1000, 32'h0000_AAAA, 32'h0000_0104, 5'd5,
              1'b1, 1'b0, 1'b0, 2'd0, 3'd2);
        step(mk(1,1,0,0, 2'd0, 3'd2, 5'd5, 32'h1000, 32'hAAAA, 32'h104, 1, 32'h1000, 16'd0, 16'd0));

        // three stall edges with changing inputs: contents hold
        for (int k = 1; k <= 3; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'(k[0]), 32'hDEAD + 32'(k), 32'h55, 32'h200, 5'd9,
                  1'b1, 1'b0, 1'b1, 2'd2, 3'd5);
            step(mk(1,1,0,0, 2'd0, 3'd2, 5'd5, 32'h1000, 32'hAAAA, 32'h104, 1, 32'h1000,
                    16'(k), 16'd0));
        end

        // stall and flush together: flush wins, counters see a bubble only
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'hDEAD, 32'h55, 32'h200, 5'd9, 1'b1, 1'b0, 1'b1,
              2'd2, 3'd5);
        e = mk(0,0,0,0, 2'd0, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 16'd3, 16'd1);
        e.chk_zf = 1'b1;  e.zf_valid = 1'b0;  e.zf_alu = 32'h1000;
        e.chk_s4 = 1'b1;  e.s4_scnt = 4'd3;
        step(e);

        // write to x0 is squashed
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h11, 32'h22, 32'h33, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0);
        step(mk(1,0,0,0, 2'd0, 3'd0, 5'd0, 32'h11, 32'h22, 32'h33, 0, 32'h11, 16'd3, 16'd1));

        // load instruction: not forwardable
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h2000, 32'h0, 32'h44, 5'd7, 1'b1, 1'b1, 1'b0, 2'd1, 3'd4);
        step(mk(1,1,1,0, 2'd1, 3'd4, 5'd7, 32'h2000, 32'h0, 32'h44, 0, 32'h2000, 16'd3, 16'd1));

        // JAL-style link: forward pc_p_4
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h99, 32'h5, 32'h84, 5'd1, 1'b1, 1'b0, 1'b0, 2'd2, 3'd0);
        step(mk(1,1,0,0, 2'd2, 3'd0, 5'd1, 32'h99, 32'h5, 32'h84, 1, 32'h84, 16'd3, 16'd1));

        // invalid slot: control gated off, data captured, counted as bubble
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h77, 32'h66, 32'h88, 5'd3, 1'b1, 1'b0, 1'b1, 2'd0, 3'd1);
        step(mk(0,0,0,0, 2'd0, 3'd1, 5'd3, 32'h77, 32'h66, 32'h88, 0, 32'h77, 16'd3, 16'd2));

        // store
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 32'h1234, 32'h10, 5'd0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd2);
        step(mk(1,0,0,1, 2'd0, 3'd2, 5'd0, 32'h300, 32'h1234, 32'h10, 0, 32'h300, 16'd3, 16'd2));

        // flush alone: zeroed here, data held in the ZERO_ON_FLUSH=0 copy
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h400, 32'h1, 32'h2, 5'd4, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0);
        e = mk(0,0,0,0, 2'd0, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 16'd3, 16'd3);
        e.chk_zf = 1'b1;  e.zf_valid = 1'b0;  e.zf_alu = 32'h300;
        step(e);

        // 20 stall edges: 4-bit counter saturates at 0xF
        for (int k = 1; k <= 20; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h500 + 32'(k), 32'h7, 32'h8, 5'd6, 1'b1, 1'b0,
                  1'b0, 2'd0, 3'd0);
            e = mk(0,0,0,0, 2'd0, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 16'(3 + k), 16'd3);
            e.chk_s4 = 1'b1;
            e.s4_scnt = (3 + k > 15) ? 4'hF : 4'(3 + k);
            step(e);
        end

        // reset in the middle of a stall clears everything
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h600, 32'h7, 32'h8, 5'd6, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0);
        e = mk(0,0,0,0, 2'd0, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 16'd0, 16'd0);
        e.chk_s4 = 1'b1;  e.s4_scnt = 4'd0;
        step(e);

        // first edge after reset loads normally
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1000, 32'h0000_AAAA, 32'h0000_0104, 5'd5,
              1'b1, 1'b0, 1'b0, 2'd0, 3'd2);
        step(mk(1,1,0,0, 2'd0, 3'd2, 5'd5, 32'h1000, 32'hAAAA, 32'h104, 1, 32'h1000, 16'd0, 16'd0));

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        #5;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
